// File: rtl/data_mem_mmio.sv
// ----------------------------------------------------------------------------
// data_mem_mmio
//
// Data memory for the MEM stage of the pipelined MIPS core. It pairs a
// byte-lane writable RAM with a small memory-mapped peripheral block. The
// peripherals are a reload timer with an interrupt, an LED register, a
// free-running cycle counter (SYSTICK) and an autonomous 4-digit
// seven-segment scanner.
//
// Bus handshake: there is no valid/ready pairing. MemWrite is a single-cycle
// write strobe that is committed at the rising edge. MemRead qualifies a
// combinational load; Read_data is zero whenever MemRead is low.
//
// Ports
//   clk        : sole clock, all state changes on the rising edge
//   reset      : synchronous, active-low
//   Address    : byte address; [31:28]==4'h4 selects MMIO, else RAM (wraps)
//   Write_data : store data
//   MemRead    : load strobe
//   MemWrite   : store strobe
//   ByteEn     : RAM write lane mask (MMIO writes are always full word)
//   Read_data  : combinational load data
//   leds       : LED register
//   BCDData    : active-low segments {dp,g,f,e,d,c,b,a}
//   an         : active-low one-hot digit select
//   irq        : timer interrupt (TCON[2])
// ----------------------------------------------------------------------------
module data_mem_mmio #(
    parameter int RAM_WORDS     = 512,
    parameter int RAM_ADDR_BITS = 9,
    parameter int SCAN_DIV      = 100000,
    parameter int LED_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          Address,
    input  logic [31:0]          Write_data,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic [3:0]           ByteEn,
    output logic [31:0]          Read_data,
    output logic [LED_WIDTH-1:0] leds,
    output logic [7:0]           BCDData,
    output logic [3:0]           an,
    output logic                 irq
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic                     is_mmio;
    logic [RAM_ADDR_BITS-1:0] word_idx;
    logic [25:0]              mmio_off;
    logic                     ram_we;
    logic                     mmio_we;
    logic [1:0]               unused_addr_lsb;

    assign is_mmio         = (Address[31:28] == 4'h4);
    assign word_idx        = Address[RAM_ADDR_BITS+1:2];
    assign mmio_off        = Address[27:2];
    assign unused_addr_lsb = Address[1:0];
    // A write in a reset cycle is discarded for the RAM as well as registers.
    assign ram_we          = MemWrite && !is_mmio && reset;
    assign mmio_we         = MemWrite && is_mmio;

    // ------------------------------------------------------------------
    // RAM: no reset so it maps onto block RAM
    // ------------------------------------------------------------------
    logic [31:0] mem [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int k = 0; k < 4; k++) begin
                if (ByteEn[k]) begin
                    mem[word_idx][8*k +: 8] <= Write_data[8*k +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Peripheral registers
    // ------------------------------------------------------------------
    logic [31:0]          th_q, th_d;
    logic [31:0]          tl_q, tl_d;
    logic [2:0]           tcon_q, tcon_d;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [19:0]          digits_q, digits_d;
    logic [31:0]          systick_q, systick_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           idx_q, idx_d;

    logic ovf;
    logic irq_set;

    always_comb begin
        ovf       = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
        irq_set   = ovf && tcon_q[1];

        th_d      = th_q;
        tl_d      = tl_q;
        tcon_d    = {tcon_q[2] | irq_set, tcon_q[1:0]};
        led_d     = led_q;
        digits_d  = digits_q;
        systick_d = systick_q + 32'd1;

        if (tcon_q[0]) begin
            tl_d = ovf ? th_q : (tl_q + 32'd1);
        end

        // CPU writes take priority over the count; the overflow status set
        // is OR-ed in so a clear in the overflow cycle cannot lose it.
        if (mmio_we) begin
            case (mmio_off)
                26'd0: th_d     = Write_data;
                26'd1: tl_d     = Write_data;
                26'd2: tcon_d   = {Write_data[2] | irq_set, Write_data[1:0]};
                26'd3: led_d    = Write_data[LED_WIDTH-1:0];
                26'd4: digits_d = Write_data[19:0];
                default: ;
            endcase
        end

        // Scanner: hold each digit SCAN_DIV cycles.
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            tcon_q    <= '0;
            led_q     <= '0;
            digits_q  <= '0;
            systick_q <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digits_q  <= digits_d;
            systick_q <= systick_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    always_comb begin
        Read_data = 32'd0;
        if (MemRead) begin
            if (is_mmio) begin
                case (mmio_off)
                    26'd0:   Read_data = th_q;
                    26'd1:   Read_data = tl_q;
                    26'd2:   Read_data = {29'd0, tcon_q};
                    26'd3:   Read_data = 32'(led_q);
                    26'd4:   Read_data = {12'd0, digits_q};
                    26'd5:   Read_data = systick_q;
                    default: Read_data = 32'd0;
                endcase
            end else begin
                Read_data = mem[word_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Display: decoded from registers only
    // ------------------------------------------------------------------
    logic [3:0] nibble;
    logic [3:0] dp_en;
    logic [6:0] seg;

    assign nibble = digits_q[{idx_q, 2'b00} +: 4];
    assign dp_en  = digits_q[19:16];

    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

    assign an      = ~(4'b0001 << idx_q);
    assign BCDData = {~dp_en[idx_q], seg};
    assign leds    = led_q;
    assign irq     = tcon_q[2];

endmodule
